// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Packed-BCD image of a constant, up to 8 digits; callers slice what they need.
    function automatic logic [31:0] to_bcd_const(input int unsigned val);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = val;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj3.sv
// One double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_adj3 (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking is enabled by defining BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W   = 14,
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int unsigned        CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned        BCD_W   = 4 * DIGITS;
    localparam logic [31:0]        SAT_ALL = to_bcd_const(MAX_VAL);
    localparam logic [BCD_W-1:0]   SAT_BCD = SAT_ALL[BCD_W-1:0];

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_next_q, ovf_next_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               busy_q;

    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   scr_shift;
    logic [BIN_W-1:0]   bin_shift;
    logic [BCD_W-1:0]   load_val;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .nibble   (scr_q[4*g +: 4]),
            .adjusted (scr_adj[4*g +: 4])
        );
    end

    // Bits leaving the top of the scratch register are dropped; saturation covers them.
    assign scr_shift = {scr_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    assign bin_shift = {bin_q[BIN_W-2:0], 1'b0};

    always_comb begin
        load_val = ovf_next_q ? SAT_BCD : scr_shift;
`ifdef BIN2BCD_LZ_BLANK_EN
        begin : blank_lz
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (lead && load_val[4*i +: 4] == 4'd0) begin
                    load_val[4*i +: 4] = BLANK_CODE;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d      = bin_in;
                    scr_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_next_d = 32'(bin_in) > MAX_VAL;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = scr_shift;
                bin_d = bin_shift;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = load_val;
                    ovf_d   = ovf_next_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with a few random back-to-back runs.
module tb_bin2bcd_seq;

    localparam int BIN_W = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin_in = '0;
    logic        busy, done, ovf;
    logic [15:0] bcd_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_e0 = 0;
    int this_e0 = 0;

    bin2bcd_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected display code: leading zero digits above digit 0 blank when enabled.
    function automatic logic [15:0] lz(input logic [15:0] x);
        logic [15:0] r;
        r = x;
`ifdef BIN2BCD_LZ_BLANK_EN
        for (int i = 3; i > 0; i--) begin
            if (r[4*i +: 4] != 4'd0) break;
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int t;
        t = (v > 9999) ? 9999 : v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return lz(r);
    endfunction

    // Starts a conversion now (between edges) and checks latency, result and done width.
    task automatic run_conv(input string tag, input int v, input logic [15:0] exp_bcd,
                            input logic exp_ovf);
        int k;
        bin_in = 14'(v);
        start  = 1'b1;
        step();
        this_e0 = cyc;
        start  = 1'b0;
        bin_in = 14'h3FFF;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        do begin
            step();
            k++;
        end while (!done && k < 40);
        chk({tag, "_lat"}, k, BIN_W);
        chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        step();
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        int v;
        logic saw_done;

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        step();

        run_conv("c1234", 1234, 16'h1234, 1'b0);
        run_conv("c0", 0, lz(16'h0000), 1'b0);
        run_conv("c9999", 9999, 16'h9999, 1'b0);
        run_conv("c10000", 10000, 16'h9999, 1'b1);
        run_conv("c16383", 16383, 16'h9999, 1'b1);
        run_conv("c7", 7, lz(16'h0007), 1'b0);

        // Start held high with a different value through the whole busy window.
        bin_in = 14'd42;
        start  = 1'b1;
        step();
        bin_in = 14'd555;
        ndone  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) begin
                ndone++;
                chk("ign_bcd", 32'(bcd_out), 32'(lz(16'h0042)));
            end
            if (!busy) break;
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);
        step();
        run_conv("c555", 555, lz(16'h0555), 1'b0);

        // Asynchronous abort partway through a conversion.
        bin_in = 14'd8888;
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd_out), 32'd0);
        step();
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            step();
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        // Back-to-back random conversions, each started the cycle busy falls.
        last_e0 = 0;
        for (int n = 0; n < 8; n++) begin
            v = (n == 0) ? 16383 : int'($urandom_range(0, 16383));
            run_conv($sformatf("rnd%0d", n), v, ref_bcd(v), 1'(v > 9999));
            if (n > 0) chk($sformatf("rnd%0d_gap", n), this_e0 - last_e0, BIN_W + 2);
            last_e0 = this_e0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
